// File: rtl/node3_packet_arbiter.sv
// Wormhole crossbar arbiter for the 3-port router node: per-output round-robin with packet locking.
// Optional forced release of stalled locks is compiled in with `define ARB_TIMEOUT_EN.
module node3_packet_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           packet_valid,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] route_req,
  input  logic [NUM_PORTS*LEN_W-1:0]     head_len,
  input  logic [NUM_PORTS-1:0]           buffer_full_in,
  output logic [NUM_PORTS*NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0]           grant_v,
  output logic [NUM_PORTS-1:0]           pop_v,
  output logic [NUM_PORTS-1:0]           busy,
  output logic                           timeout_err
);

  if (NUM_PORTS != 3 || TIMEOUT < 2) begin : g_bad_cfg
    $error("node3_packet_arbiter supports NUM_PORTS=3 and TIMEOUT>=2 only");
  end

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t           state_q [NUM_PORTS];
  state_t           state_d [NUM_PORTS];
  logic [1:0]       owner_q [NUM_PORTS];
  logic [1:0]       owner_d [NUM_PORTS];
  logic [1:0]       rr_q    [NUM_PORTS];
  logic [1:0]       rr_d    [NUM_PORTS];
  logic [LEN_W-1:0] rem_q   [NUM_PORTS];
  logic [LEN_W-1:0] rem_d   [NUM_PORTS];

  logic [NUM_PORTS-1:0] owns;
  logic [NUM_PORTS-1:0] req_m   [NUM_PORTS];
  logic [NUM_PORTS-1:0] eff_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] found;
  logic [1:0]           win     [NUM_PORTS];
  logic [NUM_PORTS-1:0] xfer;

`ifdef ARB_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT);
  logic [ST_W-1:0] stall_q [NUM_PORTS];
  logic [ST_W-1:0] stall_d [NUM_PORTS];
`else
  assign timeout_err = 1'b0;
`endif

  // Request decode: drop U-turn, keep lowest set bit, mask inputs already owning an output.
  always_comb begin
    owns = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == S_LOCKED) owns[owner_q[o]] = 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_m[i]    = route_req[NUM_PORTS*i +: NUM_PORTS];
      req_m[i][i] = 1'b0;
      eff_req[i]  = owns[i] ? '0 : (req_m[i] & (~req_m[i] + 1'b1));
    end
  end

  always_comb begin
    found = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      win[o] = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (!found[o] && packet_valid[(int'(rr_q[o]) + k) % NUM_PORTS] &&
            eff_req[(int'(rr_q[o]) + k) % NUM_PORTS][o]) begin
          found[o] = 1'b1;
          win[o]   = 2'((int'(rr_q[o]) + k) % NUM_PORTS);
        end
      end
    end
  end

  always_comb begin
    grant   = '0;
    grant_v = '0;
    pop_v   = '0;
    busy    = '0;
    xfer    = '0;
`ifdef ARB_TIMEOUT_EN
    timeout_err = 1'b0;
`endif
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      rem_d[o]   = rem_q[o];
`ifdef ARB_TIMEOUT_EN
      stall_d[o] = stall_q[o];
`endif
      case (state_q[o])
        S_IDLE: begin
          if (found[o] && !buffer_full_in[o]) begin
            grant[NUM_PORTS*o + int'(win[o])] = 1'b1;
            grant_v[o]   = 1'b1;
            pop_v[win[o]] = 1'b1;
            owner_d[o]   = win[o];
            rr_d[o]      = win[o];
            rem_d[o]     = head_len[LEN_W*int'(win[o]) +: LEN_W];
            if (head_len[LEN_W*int'(win[o]) +: LEN_W] != '0) state_d[o] = S_LOCKED;
`ifdef ARB_TIMEOUT_EN
            stall_d[o] = '0;
`endif
          end
        end
        S_LOCKED: begin
          busy[o] = 1'b1;
          grant[NUM_PORTS*o + int'(owner_q[o])] = 1'b1;
          xfer[o]    = packet_valid[owner_q[o]] & ~buffer_full_in[o];
          grant_v[o] = xfer[o];
          if (xfer[o]) begin
            pop_v[owner_q[o]] = 1'b1;
            rem_d[o] = rem_q[o] - 1'b1;
            if (rem_q[o] == LEN_W'(1)) state_d[o] = S_IDLE;
`ifdef ARB_TIMEOUT_EN
            stall_d[o] = '0;
          end else if (stall_q[o] == ST_W'(TIMEOUT - 1)) begin
            state_d[o]  = S_IDLE;
            rr_d[o]     = owner_q[o];
            stall_d[o]  = '0;
            timeout_err = 1'b1;
          end else begin
            stall_d[o] = stall_q[o] + 1'b1;
`endif
          end
        end
        default: state_d[o] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (rst) begin
        state_q[o] <= S_IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= 2'(NUM_PORTS - 1);
        rem_q[o]   <= '0;
`ifdef ARB_TIMEOUT_EN
        stall_q[o] <= '0;
`endif
      end else begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
        rem_q[o]   <= rem_d[o];
`ifdef ARB_TIMEOUT_EN
        stall_q[o] <= stall_d[o];
`endif
      end
    end
  end

endmodule

// File: tb/tb_node3_packet_arbiter.sv
// Directed bench for node3_packet_arbiter (default build, timeout feature off).
module tb_node3_packet_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] packet_valid;
  logic [8:0] route_req;
  logic [23:0] head_len;
  logic [2:0] buffer_full_in;
  logic [8:0] grant;
  logic [2:0] grant_v;
  logic [2:0] pop_v;
  logic [2:0] busy;
  logic       timeout_err;

  int n_total = 0;
  int n_pass  = 0;

  node3_packet_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .packet_valid   (packet_valid),
    .route_req      (route_req),
    .head_len       (head_len),
    .buffer_full_in (buffer_full_in),
    .grant          (grant),
    .grant_v        (grant_v),
    .pop_v          (pop_v),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_gv, input logic [2:0] e_pop,
                         input logic [2:0] e_busy, input logic [8:0] e_gnt);
    chk({tag, ".grant_v"}, 32'(grant_v), 32'(e_gv));
    chk({tag, ".pop_v"},   32'(pop_v),   32'(e_pop));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".grant"},   32'(grant),   32'(e_gnt));
    chk({tag, ".tmo"},     32'(timeout_err), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    packet_valid = '0; route_req = '0; head_len = '0; buffer_full_in = '0;
    @(negedge clk);
    #1;
    chk_all(tag, 3'b000, 3'b000, 3'b000, 9'h000);
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, then check the combinational outputs.
  task automatic step(input string tag, input logic [2:0] pv, input logic [8:0] rq,
                      input logic [23:0] hl, input logic [2:0] fl,
                      input logic [2:0] e_gv, input logic [2:0] e_pop,
                      input logic [2:0] e_busy, input logic [8:0] e_gnt);
    @(negedge clk);
    packet_valid = pv; route_req = rq; head_len = hl; buffer_full_in = fl;
    #1;
    chk_all(tag, e_gv, e_pop, e_busy, e_gnt);
  endtask

  initial begin
    rst = 1'b1;
    packet_valid = '0; route_req = '0; head_len = '0; buffer_full_in = '0;

    // in0, len=2, to out1: three transfers, busy during the two body flits
    do_reset("rst1");
    step("p1_hdr",  3'b001, 9'h002, 24'h000002, 3'b000, 3'b010, 3'b001, 3'b000, 9'h008);
    step("p1_b1",   3'b001, 9'h002, 24'h000002, 3'b000, 3'b010, 3'b001, 3'b010, 9'h008);
    step("p1_b2",   3'b001, 9'h002, 24'h000002, 3'b000, 3'b010, 3'b001, 3'b010, 9'h008);
    step("p1_idle", 3'b000, 9'h002, 24'h000002, 3'b000, 3'b000, 3'b000, 3'b000, 9'h000);

    // in0 and in2 contend for out1 with header-only packets: strict alternation from in0
    do_reset("rst2");
    step("rr_a", 3'b101, 9'h082, 24'h0, 3'b000, 3'b010, 3'b001, 3'b000, 9'h008);
    step("rr_b", 3'b101, 9'h082, 24'h0, 3'b000, 3'b010, 3'b100, 3'b000, 9'h020);
    step("rr_c", 3'b101, 9'h082, 24'h0, 3'b000, 3'b010, 3'b001, 3'b000, 9'h008);
    step("rr_d", 3'b101, 9'h082, 24'h0, 3'b000, 3'b010, 3'b100, 3'b000, 9'h020);

    // in2 len=3 locks out0; in1 asks mid-packet and waits until the 4th flit is gone
    do_reset("rst3");
    step("lk_hdr", 3'b100, 9'h040, 24'h030000, 3'b000, 3'b001, 3'b100, 3'b000, 9'h004);
    step("lk_b1",  3'b110, 9'h048, 24'h030000, 3'b000, 3'b001, 3'b100, 3'b001, 9'h004);
    step("lk_b2",  3'b110, 9'h048, 24'h030000, 3'b000, 3'b001, 3'b100, 3'b001, 9'h004);
    step("lk_b3",  3'b110, 9'h048, 24'h030000, 3'b000, 3'b001, 3'b100, 3'b001, 9'h004);
    step("lk_in1", 3'b010, 9'h008, 24'h000000, 3'b000, 3'b001, 3'b010, 3'b000, 9'h002);

    // in0 len=3 to out2, downstream full for 5 cycles mid-body
    do_reset("rst4");
    step("st_hdr", 3'b001, 9'h004, 24'h000003, 3'b000, 3'b100, 3'b001, 3'b000, 9'h040);
    step("st_b1",  3'b001, 9'h004, 24'h000003, 3'b000, 3'b100, 3'b001, 3'b100, 9'h040);
    for (int c = 0; c < 5; c++)
      step("st_full", 3'b001, 9'h004, 24'h000003, 3'b100, 3'b000, 3'b000, 3'b100, 9'h040);
    step("st_b2",   3'b001, 9'h004, 24'h000003, 3'b000, 3'b100, 3'b001, 3'b100, 9'h040);
    step("st_b3",   3'b001, 9'h004, 24'h000003, 3'b000, 3'b100, 3'b001, 3'b100, 9'h040);
    step("st_done", 3'b000, 9'h004, 24'h000003, 3'b000, 3'b000, 3'b000, 3'b000, 9'h000);

    // in0->out1 and in1->out2 in the same cycle
    do_reset("rst5");
    step("par", 3'b011, 9'h022, 24'h0, 3'b000, 3'b110, 3'b011, 3'b000, 9'h088);

    // in1 asks {out1 (U-turn), out0}: U-turn dropped, lowest remaining bit wins
    do_reset("rst6");
    step("uturn", 3'b010, 9'h018, 24'h0, 3'b000, 3'b001, 3'b010, 3'b000, 9'h002);

    // out2 full while idle: no grant and pointer kept, so in0 still wins afterwards
    do_reset("rst7");
    step("if_full", 3'b011, 9'h024, 24'h0, 3'b100, 3'b000, 3'b000, 3'b000, 9'h000);
    step("if_go",   3'b011, 9'h024, 24'h0, 3'b000, 3'b100, 3'b001, 3'b000, 9'h040);
    step("if_next", 3'b011, 9'h024, 24'h0, 3'b000, 3'b100, 3'b010, 3'b000, 9'h080);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
